// File: rtl/processor_stage_pkg.sv
// Shared stage encodings, halt cause codes and CCR bit positions for the
// five-stage processor sequencer.
package processor_stage_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_DECODE    = 3'd2,
      ST_EXECUTE   = 3'd3,
      ST_MEMORY    = 3'd4,
      ST_WRITEBACK = 3'd5,
      ST_HALT      = 3'd7
   } stage_e;

   typedef enum logic [1:0] {
      HC_NONE    = 2'd0,
      HC_IFNR    = 2'd1,
      HC_INR     = 2'd2,
      HC_TIMEOUT = 2'd3
   } halt_cause_e;

   localparam int CCR_C    = 0;
   localparam int CCR_V    = 1;
   localparam int CCR_Z    = 2;
   localparam int CCR_N    = 3;
   localparam int CCR_INR  = 4;
   localparam int CCR_IFNR = 5;
   localparam int CCR_NOP  = 6;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled memory cycles; Timeout_o flags the MEM_TIMEOUT-th
// consecutive stall combinationally. Clear_i wins over Waiting_i.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic Clock_i,
   input  logic Reset_n_i,
   input  logic Clear_i,
   input  logic Waiting_i,
   output logic Timeout_o
);

   localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (Clear_i) begin
         count_d = '0;
      end else if (Waiting_i) begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge Clock_i) begin
      if (!Reset_n_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // The count never passes MEM_TIMEOUT-1: reaching it while stalled forces a state change.
   assign Timeout_o = Waiting_i && (count_q == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle Fetch/Decode/Execute/Memory/WriteBack sequencer; 5 cycles per instruction
// (2 for a NOP) with no stalls, holding in FETCH/MEMORY while MEM_Ready is low.
module stage_sequencer
   import processor_stage_pkg::*;
#(
   parameter int COUNT_WIDTH = 32,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                   Clock_i,
   input  logic                   Reset_n_i,
   input  logic                   Run_i,
   input  logic                   Step_Mode_i,
   input  logic                   MEM_Ready_i,
   input  logic                   Memory_Access_i,
   input  logic                   NOP_FLAG_i,
   input  logic                   IFNR_FLAG_i,
   input  logic [31:0]            CCR_Out_i,
   output logic [2:0]             Stage_o,
   output logic [4:0]             Stage_OneHot_o,
   output logic                   Mem_Request_o,
   output logic                   Stall_o,
   output logic                   Halted_o,
   output logic [1:0]             Halt_Cause_o,
   output logic [COUNT_WIDTH-1:0] Instr_Count_o
);

   stage_e                 state_q, state_d;
   halt_cause_e            cause_q, cause_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   mem_first_q;
   logic                   inr_hit;
   logic                   mem_req;
   logic                   timeout;
   logic                   continue_run;
   logic                   unused_ccr;

   assign unused_ccr = ^{CCR_Out_i[31:CCR_INR+1], CCR_Out_i[CCR_INR-1:0]};

   // MEMORY is only ever entered from EXECUTE, so this marks its first cycle.
   assign inr_hit = (state_q == ST_MEMORY) && mem_first_q && CCR_Out_i[CCR_INR];
   assign mem_req = (state_q == ST_FETCH) ||
                    ((state_q == ST_MEMORY) && Memory_Access_i && !inr_hit);
   assign continue_run = Run_i && !Step_Mode_i;

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
      .Clock_i   (Clock_i),
      .Reset_n_i (Reset_n_i),
      .Clear_i   (state_d != state_q),
      .Waiting_i (mem_req && !MEM_Ready_i),
      .Timeout_o (timeout)
   );

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      count_d = count_q;
      case (state_q)
         ST_IDLE: if (Run_i) state_d = ST_FETCH;
         ST_FETCH: begin
            if (MEM_Ready_i) begin
               state_d = ST_DECODE;
            end else if (timeout) begin
               state_d = ST_HALT;
               cause_d = HC_TIMEOUT;
            end
         end
         ST_DECODE: begin
            if (IFNR_FLAG_i) begin
               state_d = ST_HALT;
               cause_d = HC_IFNR;
            end else if (NOP_FLAG_i) begin
               count_d = count_q + COUNT_WIDTH'(1);
               state_d = continue_run ? ST_FETCH : ST_IDLE;
            end else begin
               state_d = ST_EXECUTE;
            end
         end
         ST_EXECUTE: state_d = ST_MEMORY;
         ST_MEMORY: begin
            if (inr_hit) begin
               state_d = ST_HALT;
               cause_d = HC_INR;
            end else if (!Memory_Access_i || MEM_Ready_i) begin
               state_d = ST_WRITEBACK;
            end else if (timeout) begin
               state_d = ST_HALT;
               cause_d = HC_TIMEOUT;
            end
         end
         ST_WRITEBACK: begin
            count_d = count_q + COUNT_WIDTH'(1);
            state_d = continue_run ? ST_FETCH : ST_IDLE;
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clock_i) begin
      if (!Reset_n_i) begin
         state_q     <= ST_IDLE;
         cause_q     <= HC_NONE;
         count_q     <= '0;
         mem_first_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cause_q     <= cause_d;
         count_q     <= count_d;
         mem_first_q <= (state_q == ST_EXECUTE);
      end
   end

   always_comb begin
      Stage_OneHot_o = 5'b00000;
      case (state_q)
         ST_FETCH:     Stage_OneHot_o = 5'b00001;
         ST_DECODE:    Stage_OneHot_o = 5'b00010;
         ST_EXECUTE:   Stage_OneHot_o = 5'b00100;
         ST_MEMORY:    Stage_OneHot_o = 5'b01000;
         ST_WRITEBACK: Stage_OneHot_o = 5'b10000;
         default:      Stage_OneHot_o = 5'b00000;
      endcase
   end

   assign Stage_o       = state_q;
   assign Mem_Request_o = mem_req;
   assign Stall_o       = mem_req && !MEM_Ready_i;
   assign Halted_o      = (state_q == ST_HALT);
   assign Halt_Cause_o  = cause_q;
   assign Instr_Count_o = count_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: directed scenarios followed by random stimulus,
// every cycle compared against a stage-level reference model.
module tb_stage_sequencer;

   localparam int CW = 4;
   localparam int TO = 4;

   logic          Clock = 1'b0;
   logic          Reset_n, Run, Step_Mode, MEM_Ready, Memory_Access, NOP_FLAG, IFNR_FLAG;
   logic [31:0]   CCR_Out;
   logic [2:0]    Stage;
   logic [4:0]    Stage_OneHot;
   logic          Mem_Request, Stall, Halted;
   logic [1:0]    Halt_Cause;
   logic [CW-1:0] Instr_Count;

   stage_sequencer #(.COUNT_WIDTH(CW), .MEM_TIMEOUT(TO)) dut (
      .Clock_i         (Clock),
      .Reset_n_i       (Reset_n),
      .Run_i           (Run),
      .Step_Mode_i     (Step_Mode),
      .MEM_Ready_i     (MEM_Ready),
      .Memory_Access_i (Memory_Access),
      .NOP_FLAG_i      (NOP_FLAG),
      .IFNR_FLAG_i     (IFNR_FLAG),
      .CCR_Out_i       (CCR_Out),
      .Stage_o         (Stage),
      .Stage_OneHot_o  (Stage_OneHot),
      .Mem_Request_o   (Mem_Request),
      .Stall_o         (Stall),
      .Halted_o        (Halted),
      .Halt_Cause_o    (Halt_Cause),
      .Instr_Count_o   (Instr_Count)
   );

   always #5 Clock = ~Clock;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: stage number, cycles spent in that stage, retired count, halt cause.
   int m_stage, m_in, m_cnt, m_cause;

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cycle(input logic rst, input logic run, input logic step, input logic rdy,
                        input logic ma, input logic nop, input logic ifnr, input logic [31:0] ccr);
      logic e_req, e_stall, tmo;
      int   ns, nc, ncnt;
      Reset_n = rst; Run = run; Step_Mode = step; MEM_Ready = rdy;
      Memory_Access = ma; NOP_FLAG = nop; IFNR_FLAG = ifnr; CCR_Out = ccr;
      #3;
      e_req   = (m_stage == 1) || (m_stage == 4 && ma && !(m_in == 0 && ccr[4]));
      e_stall = e_req && !rdy;
      chk_val("stage", 32'(Stage), m_stage);
      chk_val("onehot", 32'(Stage_OneHot), (m_stage >= 1 && m_stage <= 5) ? (1 << (m_stage - 1)) : 0);
      chk_val("mem_request", 32'(Mem_Request), 32'(e_req));
      chk_val("stall", 32'(Stall), 32'(e_stall));
      chk_val("halted", 32'(Halted), 32'(m_stage == 7));
      chk_val("halt_cause", 32'(Halt_Cause), m_cause);
      chk_val("instr_count", 32'(Instr_Count), m_cnt);

      // The TO-th consecutive stalled cycle of one access halts unless memory answers.
      tmo  = e_stall && (m_in == TO - 1);
      ns   = m_stage;
      nc   = m_cause;
      ncnt = m_cnt;
      case (m_stage)
         0: if (run) ns = 1;
         1: if (rdy) ns = 2; else if (tmo) begin ns = 7; nc = 3; end
         2: if (ifnr) begin ns = 7; nc = 1; end
            else if (nop) begin ncnt = (m_cnt + 1) % (1 << CW); ns = (run && !step) ? 1 : 0; end
            else ns = 3;
         3: ns = 4;
         4: if (m_in == 0 && ccr[4]) begin ns = 7; nc = 2; end
            else if (!ma || rdy) ns = 5;
            else if (tmo) begin ns = 7; nc = 3; end
         5: begin ncnt = (m_cnt + 1) % (1 << CW); ns = (run && !step) ? 1 : 0; end
         default: ns = 7;
      endcase
      @(posedge Clock);
      #1;
      if (!rst) begin
         m_stage = 0; m_in = 0; m_cnt = 0; m_cause = 0;
      end else begin
         m_in    = (ns == m_stage) ? m_in + 1 : 0;
         m_stage = ns; m_cause = nc; m_cnt = ncnt;
      end
   endtask

   initial begin
      int   halt_age;
      logic r_rst;
      logic [31:0] r_ccr;
      Reset_n = 1'b0; Run = 1'b0; Step_Mode = 1'b0; MEM_Ready = 1'b0;
      Memory_Access = 1'b0; NOP_FLAG = 1'b0; IFNR_FLAG = 1'b0; CCR_Out = 32'h0;
      @(posedge Clock);
      #1;
      m_stage = 0; m_in = 0; m_cnt = 0; m_cause = 0;

      // Reset and plain instruction flow
      repeat (2) cycle(0, 0, 0, 1, 0, 0, 0, 32'h0);
      chk_val("rst_stage", 32'(Stage), 0);
      chk_val("rst_count", 32'(Instr_Count), 0);
      cycle(1, 1, 0, 1, 0, 0, 0, 32'h0);
      chk_val("idle_to_fetch", 32'(Stage), 1);
      repeat (5) cycle(1, 1, 0, 1, 0, 0, 0, 32'h0);
      chk_val("first_wb_stage", 32'(Stage), 1);
      chk_val("first_wb_count", 32'(Instr_Count), 1);

      // Fetch stall below the timeout
      repeat (3) cycle(1, 1, 0, 0, 0, 0, 0, 32'h0);
      chk_val("fetch_stall_hold", 32'(Stage), 1);
      cycle(1, 1, 0, 1, 0, 0, 0, 32'h0);
      chk_val("fetch_release", 32'(Stage), 2);
      chk_val("fetch_no_halt", 32'(Halted), 0);

      // NOP retires from DECODE
      cycle(1, 1, 0, 1, 0, 1, 0, 32'h0);
      chk_val("nop_stage", 32'(Stage), 1);
      chk_val("nop_count", 32'(Instr_Count), 2);

      // Memory timeout
      repeat (3) cycle(1, 1, 0, 1, 0, 0, 0, 32'h0);
      repeat (4) cycle(1, 1, 0, 0, 1, 0, 0, 32'h0);
      chk_val("timeout_stage", 32'(Stage), 7);
      chk_val("timeout_cause", 32'(Halt_Cause), 3);
      repeat (2) cycle(1, 1, 0, 1, 0, 0, 0, 32'h0);
      chk_val("halt_sticky", 32'(Halted), 1);
      cycle(0, 1, 0, 1, 0, 0, 0, 32'h0);
      chk_val("halt_reset_stage", 32'(Stage), 0);
      chk_val("halt_reset_cause", 32'(Halt_Cause), 0);

      // Unrecognised format
      repeat (2) cycle(1, 1, 0, 1, 0, 0, 0, 32'h0);
      cycle(1, 1, 0, 1, 0, 0, 1, 32'h0);
      chk_val("ifnr_cause", 32'(Halt_Cause), 1);
      cycle(0, 0, 0, 1, 0, 0, 0, 32'h0);

      // INR at MEMORY entry with a memory op pending
      repeat (4) cycle(1, 1, 0, 1, 0, 0, 0, 32'h0);
      cycle(1, 1, 0, 1, 1, 0, 0, 32'h10);
      chk_val("inr_stage", 32'(Stage), 7);
      chk_val("inr_cause", 32'(Halt_Cause), 2);
      cycle(0, 0, 0, 1, 0, 0, 0, 32'h0);

      // Single step
      cycle(1, 1, 1, 1, 0, 0, 0, 32'h0);
      repeat (5) cycle(1, 0, 1, 1, 0, 0, 0, 32'h0);
      chk_val("step_park", 32'(Stage), 0);
      chk_val("step_count", 32'(Instr_Count), 1);
      cycle(1, 0, 1, 1, 0, 0, 0, 32'h0);
      chk_val("step_hold", 32'(Stage), 0);

      // Reset during a fetch stall, then a fresh stall must get the full budget
      cycle(1, 1, 0, 1, 0, 0, 0, 32'h0);
      repeat (2) cycle(1, 1, 0, 0, 0, 0, 0, 32'h0);
      cycle(0, 1, 0, 0, 0, 0, 0, 32'h0);
      chk_val("stall_reset_stage", 32'(Stage), 0);
      chk_val("stall_reset_count", 32'(Instr_Count), 0);
      cycle(1, 1, 0, 1, 0, 0, 0, 32'h0);
      repeat (3) cycle(1, 1, 0, 0, 0, 0, 0, 32'h0);
      cycle(1, 1, 0, 1, 0, 0, 0, 32'h0);
      chk_val("wait_cleared", 32'(Stage), 2);

      // Random traffic
      halt_age = 0;
      repeat (3000) begin
         r_rst = !(($urandom_range(63) == 0) || (halt_age > 8));
         r_ccr = ($urandom & 32'hFFFF_FFEF) | (($urandom_range(19) == 0) ? 32'h10 : 32'h0);
         cycle(r_rst, $urandom_range(9) != 0, $urandom_range(4) == 0, $urandom_range(9) < 7,
               $urandom_range(1) == 1, $urandom_range(4) == 0, $urandom_range(29) == 0, r_ccr);
         halt_age = (m_stage == 7) ? halt_age + 1 : 0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
